vga_draw_scheduler: RTL and testbench

//  Command scheduler that owns the VGA adapter pixel-write port. Requesters push box or

---
 rtl/vga_draw_scheduler.sv | 140 ++++++++++++++
 tb/tb_vga_draw_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_scheduler.sv
// Pixel-write scheduler for the VGA adapter.
// Queues box/clear commands in FIFO order and sweeps their pixels one per cycle.
module vga_draw_scheduler #(
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iCmdValid,
  output logic                        oCmdReady,
  input  logic                        iCmdClear,
  input  logic [7:0]                  iCmdX,
  input  logic [6:0]                  iCmdY,
  input  logic [2:0]                  iCmdColour,
  output logic [7:0]                  oX,
  output logic [6:0]                  oY,
  output logic [2:0]                  oColour,
  output logic                        oPlot,
  output logic                        oBusy,
  output logic                        oDone,
  output logic [$clog2(FIFO_DEPTH):0] oQueueCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       clr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BOX, S_CLEAR} state_t;

  state_t        r_state, w_state_n;
  cmd_t          r_mem [FIFO_DEPTH];
  cmd_t          r_cur;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_c;
  logic [7:0]    r_cx;
  logic [6:0]    r_cy;

  logic       w_push, w_pop, w_last, w_emit, w_qne, w_bin, w_xend;
  logic [3:0] w_nc;
  logic [7:0] w_nx;
  logic [6:0] w_ny;
  logic [8:0] w_bx;
  logic [7:0] w_by;

  assign w_qne       = (r_count != '0);
  assign oCmdReady   = (r_count != CW'(FIFO_DEPTH));
  assign w_push      = iCmdValid && oCmdReady;
  assign oBusy       = (r_state != S_IDLE) || w_qne;
  assign oQueueCount = r_count;

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_last    = 1'b0;
    w_emit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_qne) begin
          w_pop     = 1'b1;
          w_state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        w_emit    = 1'b1;
        w_state_n = r_cur.clr ? S_CLEAR : S_BOX;
      end
      S_BOX:   w_last = (r_c == 4'd15);
      S_CLEAR: w_last = w_xend && (r_cy == Y_SCREEN_PIXELS - 7'd1);
    endcase
    if (r_state == S_BOX || r_state == S_CLEAR) begin
      w_emit = !w_last;
      if (w_last) begin
        w_pop     = w_qne;
        w_state_n = w_qne ? S_FETCH : S_IDLE;
      end
    end
  end

  // Next pixel index; S_FETCH restarts every sweep at pixel 0
  assign w_xend = (r_cx == X_SCREEN_PIXELS - 8'd1);
  assign w_nc   = (r_state == S_FETCH) ? 4'd0 : r_c + 4'd1;
  assign w_nx   = (r_state == S_FETCH || w_xend) ? 8'd0 : r_cx + 8'd1;
  assign w_ny   = (r_state == S_FETCH) ? 7'd0 :
                  w_xend ? r_cy + 7'd1 : r_cy;
  assign w_bx   = {1'b0, r_cur.x} + {7'd0, w_nc[1:0]};
  assign w_by   = {1'b0, r_cur.y} + {6'd0, w_nc[3:2]};
  assign w_bin  = (w_bx < {1'b0, X_SCREEN_PIXELS}) &&
                  (w_by < {1'b0, Y_SCREEN_PIXELS});

  always_ff @(posedge iClock) begin
    if (w_push) r_mem[r_wptr] <= {iCmdClear, iCmdX, iCmdY, iCmdColour};
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_cur   <= '0;
      r_c     <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_cur  <= r_mem[r_rptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_emit) begin
        r_c     <= w_nc;
        r_cx    <= w_nx;
        r_cy    <= w_ny;
        oPlot   <= r_cur.clr ? 1'b1 : w_bin;
        oX      <= r_cur.clr ? w_nx : w_bx[7:0];
        oY      <= r_cur.clr ? w_ny : w_by[6:0];
        oColour <= r_cur.clr ? 3'b000 : r_cur.col;
      end else begin
        oPlot <= 1'b0;
      end
      if (w_push)               oDone <= 1'b0;
      else if (w_last && !w_qne) oDone <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Bench for vga_draw_scheduler: reset/table vectors, corner sequences,
// and random traffic against a job-timeline reference model.
module tb_vga_draw_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, clr;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] ccol;
  logic       ready, plot, busy, done;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] ocol;
  logic [2:0] qc;

  vga_draw_scheduler dut (
    .iClock(clk), .iReset(rst), .iCmdValid(valid), .oCmdReady(ready),
    .iCmdClear(clr), .iCmdX(cx), .iCmdY(cy), .iCmdColour(ccol),
    .oX(ox), .oY(oy), .oColour(ocol), .oPlot(plot),
    .oBusy(busy), .oDone(done), .oQueueCount(qc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Reference: each popped job owns a fixed run of output frames;
  // the next pop happens on the first edge after the run ends.
  typedef struct {bit clr; int x; int y; int col;} cmd_t;
  typedef struct {int t; bit plot; int x; int y; int col;} frm_t;
  cmd_t cq[$];
  frm_t fq[$];
  frm_t cur;
  int   n = 0, free_at = 0, end_edge = -1;
  bit   m_done = 0;
  int   nplot, fx, fy, lx, ly, first_n, last_n;
  bit   saw_full;

  task automatic m_edge();
    cmd_t c;
    int   sz;
    bit   push;
    n++;
    if (rst) begin
      cq.delete();
      fq.delete();
      free_at  = n;
      end_edge = -1;
      m_done   = 0;
      cur      = '{0, 0, 0, 0, 0};
      return;
    end
    sz   = cq.size();
    push = valid && (sz < 4);
    if (n >= free_at && sz > 0) begin
      c = cq.pop_front();
      if (c.clr) begin
        for (int k = 0; k < 19200; k++)
          fq.push_back('{n + 1 + k, 1'b1, k % 160, k / 160, 0});
        free_at = n + 1 + 19200;
      end else begin
        for (int k = 0; k < 16; k++) begin
          int px, py;
          px = c.x + k % 4;
          py = c.y + k / 4;
          fq.push_back('{n + 1 + k, bit'(px < 160 && py < 120), px, py, c.col});
        end
        free_at = n + 17;
      end
      end_edge = free_at;
    end else if (n == end_edge && sz == 0 && !push) begin
      m_done = 1;
    end
    if (push) begin
      cq.push_back('{clr, int'(cx), int'(cy), int'(ccol)});
      m_done = 0;
    end
    if (fq.size() > 0 && fq[0].t == n) cur = fq.pop_front();
    else cur.plot = 0;
  endtask

  task automatic step();
    chk("ready", ready, cq.size() < 4);
    if (!ready) saw_full = 1;
    @(posedge clk);
    m_edge();
    #1;
    chk("plot", plot, cur.plot);
    if (cur.plot) begin
      chk("x", ox, cur.x);
      chk("y", oy, cur.y);
      chk("colour", ocol, cur.col);
    end
    chk("busy", busy, (n < free_at) || (cq.size() > 0));
    chk("done", done, m_done);
    chk("count", qc, cq.size());
    if (plot) begin
      if (nplot == 0) begin
        fx = ox; fy = oy; first_n = n;
      end
      lx = ox; ly = oy; last_n = n;
      nplot++;
    end
  endtask

  task automatic push(input bit c, input int x, input int y, input int col);
    bit acc;
    int g;
    valid = 1; clr = c; cx = 8'(x); cy = 7'(y); ccol = 3'(col);
    acc = 0; g = 0;
    while (!acc && g < 300) begin
      acc = ready;
      step();
      g++;
    end
    valid = 0;
    if (!acc) timeout("push");
  endtask

  task automatic drain(input int bound);
    int g;
    g = 0;
    while (busy && g < bound) begin
      step();
      g++;
    end
    if (busy) timeout("drain");
  endtask

  typedef struct {
    bit v; int x; int y; int col;
    bit eplot; int ex; int ey; int ecol; bit edone;
  } vec_t;
  vec_t tv[19];

  initial begin
    int g;
    for (int r = 0; r < 19; r++) tv[r] = '{default: 0};
    tv[0].v = 1; tv[0].x = 10; tv[0].y = 20; tv[0].col = 4;
    for (int c = 0; c < 16; c++) begin
      tv[c + 2].eplot = 1;
      tv[c + 2].ex    = 10 + c % 4;
      tv[c + 2].ey    = 20 + c / 4;
      tv[c + 2].ecol  = 4;
    end
    tv[18].edone = 1;

    rst = 1; valid = 0; clr = 0; cx = 0; cy = 0; ccol = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_x", ox, 0);
    chk("rst_y", oy, 0);
    chk("rst_colour", ocol, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_count", qc, 0);
    rst = 0;

    for (int r = 0; r < 19; r++) begin
      valid = tv[r].v; clr = 0;
      cx = 8'(tv[r].x); cy = 7'(tv[r].y); ccol = 3'(tv[r].col);
      @(posedge clk);
      #1;
      chk("t1_plot", plot, tv[r].eplot);
      if (tv[r].eplot) begin
        chk("t1_x", ox, tv[r].ex);
        chk("t1_y", oy, tv[r].ey);
        chk("t1_colour", ocol, tv[r].ecol);
      end
      chk("t1_done", done, tv[r].edone);
    end
    valid = 0;

    rst = 1; step(); rst = 0;

    nplot = 0; saw_full = 0;
    push(0, 30, 40, 1);
    repeat (3) step();
    for (int k = 0; k < 5; k++) push(0, 20 * k, 10 * k, k + 1);
    drain(400);
    chk("t2_saw_full", saw_full, 1);
    chk("t2_pixels", nplot, 96);
    chk("t2_span", last_n - first_n, 100);

    nplot = 0;
    push(0, 158, 118, 2);
    drain(100);
    chk("t3_pixels", nplot, 4);
    chk("t3_first", {fx, fy}, {158, 118});
    chk("t3_last", {lx, ly}, {159, 119});
    chk("t3_done", done, 1);

    nplot = 0;
    push(1, 0, 0, 0);
    drain(20000);
    chk("t4_pixels", nplot, 19200);
    chk("t4_first", {fx, fy}, {0, 0});
    chk("t4_last", {lx, ly}, {159, 119});
    chk("t4_done", done, 1);

    nplot = 0;
    push(1, 0, 0, 0);
    push(0, 5, 5, 7);
    push(0, 9, 9, 1);
    g = 0;
    while (nplot < 501 && g < 1000) begin
      step();
      g++;
    end
    if (nplot < 501) timeout("t5_wait");
    chk("t5_qc_before", qc, 2);
    rst = 1; step(); rst = 0;
    chk("t5_plot", plot, 0);
    chk("t5_count", qc, 0);
    chk("t5_ready", ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);

    nplot = 0;
    push(0, 50, 60, 3);
    g = 0;
    while (nplot == 0 && g < 10) begin
      step();
      g++;
    end
    push(0, 70, 80, 5);
    g = 0;
    while (n + 1 != free_at && g < 40) begin
      step();
      g++;
    end
    if (n + 1 != free_at) timeout("t6_wait");
    chk("t6_count_pre", qc, 1);
    valid = 1; clr = 0; cx = 8'd90; cy = 7'd100; ccol = 3'd6;
    step();
    valid = 0;
    chk("t6_count", qc, 1);
    drain(200);
    chk("t6_pixels", nplot, 48);

    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 2) == 0);
      clr   = 0;
      cx    = $urandom_range(0, 1) ? 8'($urandom_range(150, 255))
                                   : 8'($urandom_range(0, 159));
      cy    = $urandom_range(0, 1) ? 7'($urandom_range(110, 127))
                                   : 7'($urandom_range(0, 119));
      ccol  = 3'($urandom_range(0, 7));
      step();
    end
    valid = 0;
    drain(2000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
